// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and PC field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W     = 10;
  localparam int NUM_LINES  = 8;
  localparam int IDX_W      = 3;
  localparam int TAG_W      = ADDR_W - 4 - IDX_W;
  localparam int BLK_W      = TAG_W + IDX_W;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[4 +: IDX_W];
  endfunction

  function automatic logic [1:0] word_of(input logic [ADDR_W-1:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: async read, single write port,
// valid bits cleared asynchronously on reset (tags and data keep their contents).
module icache_line_store
  import icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_arr_r  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr_r [NUM_LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are written only on fill and never reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_arr_r[wr_idx]  <= wr_tag;
      data_arr_r[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_arr_r[rd_idx];
  assign rd_data  = data_arr_r[rd_idx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: hit compare, word select and the
// IDLE/MEM_READ/UPDATE miss FSM that fills one 16-byte line from instruction memory.
module icache_controller
  import icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] instruction,
  output logic              busywait,
  output logic              mem_read,
  output logic [BLK_W-1:0]  mem_address,
  input  logic [LINE_W-1:0] mem_readinst,
  input  logic              mem_busywait
);

  state_e             state_r, next_state_s;
  logic [BLK_W-1:0]   miss_blk_r;
  logic               mem_read_r;
  logic               latch_miss_s;
  logic               fill_s;
  logic               hit_s;
  logic               line_valid_s;
  logic [TAG_W-1:0]   line_tag_s;
  logic [LINE_W-1:0]  line_data_s;
  logic [WORD_W-1:0]  word_s;
  logic               unused_s;

  assign unused_s = ^address[1:0];

  icache_line_store u_store (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (index_of(address)),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .rd_data  (line_data_s),
    .wr_en    (fill_s),
    .wr_idx   (miss_blk_r[IDX_W-1:0]),
    .wr_tag   (miss_blk_r[BLK_W-1 -: TAG_W]),
    .wr_data  (mem_readinst)
  );

  assign hit_s = line_valid_s && (line_tag_s == tag_of(address));

  // Little-endian word select within the addressed line.
  always_comb begin
    word_s = 32'd0;
    case (word_of(address))
      2'd0:    word_s = line_data_s[31:0];
      2'd1:    word_s = line_data_s[63:32];
      2'd2:    word_s = line_data_s[95:64];
      2'd3:    word_s = line_data_s[127:96];
      default: word_s = 32'd0;
    endcase
  end

  // Next-state logic; memory is sampled only from the first edge spent in MEM_READ.
  always_comb begin
    next_state_s = state_r;
    latch_miss_s = 1'b0;
    fill_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (read && !hit_s) begin
          next_state_s = MEM_READ;
          latch_miss_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          next_state_s = UPDATE;
        end else begin
          next_state_s = MEM_READ;
        end
      end
      UPDATE: begin
        fill_s       = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, latched miss block and registered memory request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      miss_blk_r <= '0;
      mem_read_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      mem_read_r <= (next_state_s == MEM_READ);
      if (latch_miss_s) begin
        miss_blk_r <= {tag_of(address), index_of(address)};
      end
    end
  end

  // Reset forces the CPU-facing outputs low immediately, not at the next edge.
  assign busywait    = read && !reset && ((state_r != IDLE) || !hit_s);
  assign instruction = (!reset && (state_r == IDLE) && hit_s) ? word_s : 32'd0;
  assign mem_read    = mem_read_r;
  assign mem_address = miss_blk_r;

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller with a 5-cycle block memory model and an
// instruction scoreboard filled at request time and drained when busywait falls.
module tb_icache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  icache_controller dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory image: block b holds the base image with b xor-ed into the top six bits.
  function automatic logic [31:0] base_word(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0004_0019;
      2'd1:    return 32'h0005_0023;
      2'd2:    return 32'h0206_0405;
      default: return 32'h0001_005A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
    return base_word(w) ^ {blk, 26'd0};
  endfunction

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    return mem_word(a[9:4], a[3:2]);
  endfunction

  logic [2:0] lat_cnt;
  always @(posedge clock) begin
    if (!mem_read) lat_cnt <= 3'd0;
    else if (lat_cnt != 3'd5) lat_cnt <= lat_cnt + 3'd1;
  end
  assign mem_busywait = mem_read && (lat_cnt != 3'd5);
  assign mem_readinst = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                         mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [9:0] a, input bit exp_miss, input string name);
    logic [31:0] e;
    bit done;
    @(negedge clock);
    address = a;
    read    = 1'b1;
    #1;
    exp_q.push_back(exp_word(a));
    checks++;
    if (busywait !== exp_miss) begin
      errors++;
      $display("FAIL %s busywait: got %b want %b", name, busywait, exp_miss);
    end
    if (exp_miss) begin
      @(posedge clock); #1;
      checks++;
      if (mem_read !== 1'b1 || mem_address !== a[9:4]) begin
        errors++;
        $display("FAIL %s mem request: got rd=%b addr=%0d want rd=1 addr=%0d",
                 name, mem_read, mem_address, a[9:4]);
      end
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clock); #1;
        if (busywait === 1'b0) done = 1'b1;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL %s fill timeout: busywait still %b want 0", name, busywait);
      end
    end
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL %s mem_read after access: got %b want 0", name, mem_read);
    end
    e = exp_q.pop_front();
    checks++;
    if (instruction !== e) begin
      errors++;
      $display("FAIL %s instruction: got %h want %h", name, instruction, e);
    end
  endtask

  task automatic test_reset();
    read    = 1'b1;
    address = 10'h000;
    reset   = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || mem_address !== 6'd0 || instruction !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: got bw=%b rd=%b addr=%0d ins=%h want 0 0 0 0",
               busywait, mem_read, mem_address, instruction);
    end
    repeat (2) @(negedge clock);
    read  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    fetch(10'h000, 1'b1, "cold_miss");
    checks++;
    if (instruction !== 32'h0004_0019) begin
      errors++;
      $display("FAIL cold_word0: got %h want 00040019", instruction);
    end
  endtask

  task automatic test_hit();
    fetch(10'h004, 1'b0, "hit_word1");
    fetch(10'h00C, 1'b0, "hit_word3");
    fetch(10'h008, 1'b0, "hit_word2");
  endtask

  task automatic test_conflict();
    fetch(10'h080, 1'b1, "conflict_tag1");
    fetch(10'h000, 1'b1, "conflict_evicted");
  endtask

  task automatic test_index();
    fetch(10'h010, 1'b1, "index_line1");
    fetch(10'h000, 1'b0, "index_line0_kept");
    fetch(10'h014, 1'b0, "index_line1_hit");
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clock);
    address = 10'h020;
    read    = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busywait !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rd=%b bw=%b want 0 0", mem_read, busywait);
    end
    @(negedge clock);
    reset = 1'b0;
    fetch(10'h020, 1'b1, "reset_mid_retry");
    fetch(10'h000, 1'b1, "reset_mid_cleared");
  endtask

  task automatic test_idle_and_pc_change();
    int bad;
    bit done;
    @(negedge clock);
    read    = 1'b0;
    address = 10'h3F0;
    bad     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (mem_read !== 1'b0 || busywait !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d busy cycles want 0", bad);
    end
    @(negedge clock);
    address = 10'h030;
    read    = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    address = 10'h3F0;
    bad     = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      if (mem_read !== 1'b1 || mem_address !== 6'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pc_change_latch: got %0d bad cycles (addr=%0d) want 0", bad, mem_address);
    end
    read = 1'b0;
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      errors++;
      $display("FAIL read_drop_busywait: got %b want 0", busywait);
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock); #1;
      if (mem_read === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL read_drop_complete: mem_read got %b want 0", mem_read);
    end
    repeat (3) @(negedge clock);
    fetch(10'h030, 1'b0, "read_drop_filled");
    fetch(10'h03C, 1'b0, "read_drop_word3");
  endtask

  initial begin
    reset   = 1'b0;
    read    = 1'b0;
    address = 10'h000;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_index();
    test_reset_mid_fetch();
    test_idle_and_pc_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
